// File: rtl/k005297_pkg.sv
// Shared types and constants for the k005297 upstream DMA sequencer.
// The DTACK wait-state option is selected by DMASEQ_DTACK_WAIT_EN.
package k005297_pkg;

    localparam int XFER_LEN_W = 4;
    localparam int ADDR_W     = 23;
    localparam int REM_W      = XFER_LEN_W + 1;

    localparam logic [7:0] ROT8_IDLE  = 8'h00;
    localparam logic [7:0] ROT8_START = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAITBUS,
        ST_CYCLE,
        ST_RELEASE
    } state_e;

    // A zero length field encodes a full 16-word burst.
    function automatic logic [REM_W-1:0] len_words(
        input logic [XFER_LEN_W-1:0] len
    );
        return (len == '0) ? REM_W'(1 << XFER_LEN_W) : REM_W'(len);
    endfunction

endpackage

// File: rtl/k005297_dmaseq_if.sv
// Bus, buffer and timing signals between the DMA sequencer and its environment.
// master = sequencer side, slave = bus/buffer side.
interface k005297_dmaseq_if;
    import k005297_pkg::*;

    logic                  i_CLK4M_PCEN_n;
    logic                  i_CLK2M_PCEN_n;
    logic                  i_XFER_REQ;
    logic                  i_XFER_WR;
    logic [XFER_LEN_W-1:0] i_XFER_LEN;
    logic                  i_ADDR_LD;
    logic [ADDR_W-1:0]     i_ADDR;
    logic                  i_ABORT;
    logic                  i_BG_n;
    logic                  i_AS_n;
    logic                  i_DTACK_n;
    logic                  i_BGACK_n;
    logic                  o_BR_n;
    logic                  o_BGACK_n;
    logic [7:0]            o_ROT8;
    logic                  o_DMA_ACT;
    logic                  o_DMA_WR_ACT_n;
    logic [ADDR_W-1:0]     o_ADDR;
    logic                  o_WORD_ACK;
    logic                  o_XFER_DONE;

    modport master (
        input  i_CLK4M_PCEN_n, i_CLK2M_PCEN_n,
        input  i_XFER_REQ, i_XFER_WR, i_XFER_LEN,
        input  i_ADDR_LD, i_ADDR, i_ABORT,
        input  i_BG_n, i_AS_n, i_DTACK_n, i_BGACK_n,
        output o_BR_n, o_BGACK_n, o_ROT8, o_DMA_ACT,
        output o_DMA_WR_ACT_n, o_ADDR, o_WORD_ACK, o_XFER_DONE
    );

    modport slave (
        output i_CLK4M_PCEN_n, i_CLK2M_PCEN_n,
        output i_XFER_REQ, i_XFER_WR, i_XFER_LEN,
        output i_ADDR_LD, i_ADDR, i_ABORT,
        output i_BG_n, i_AS_n, i_DTACK_n, i_BGACK_n,
        input  o_BR_n, o_BGACK_n, o_ROT8, o_DMA_ACT,
        input  o_DMA_WR_ACT_n, o_ADDR, o_WORD_ACK, o_XFER_DONE
    );

endinterface

// File: rtl/k005297_rot8.sv
// One-hot 8-phase ring counter for the DMA bus cycle.
// Priority: clear, then load-start, then advance unless stalled.
module k005297_rot8
    import k005297_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_adv,
    input  logic       i_clr,
    input  logic       i_stall,
    output logic [7:0] o_rot8,
    output logic       o_last
);

    logic [7:0] rot8_q;
    logic [7:0] rot8_d;

    always_comb begin
        rot8_d = rot8_q;
        if (i_clr) begin
            rot8_d = ROT8_IDLE;
        end else if (i_load) begin
            rot8_d = ROT8_START;
        end else if (i_adv && !i_stall) begin
            rot8_d = {rot8_q[6:0], rot8_q[7]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rot8_q <= ROT8_IDLE;
        end else begin
            rot8_q <= rot8_d;
        end
    end

    assign o_rot8 = rot8_q;
    assign o_last = rot8_q[7];

endmodule

// File: rtl/k005297_dmaseq.sv
// Upstream DMA sequencer: BR/BG/BGACK arbitration, word bursts, ROT8 timing.
// Define DMASEQ_DTACK_WAIT_EN to hold phase 5 until DTACK is asserted.
module k005297_dmaseq
    import k005297_pkg::*;
(
    input  logic             i_MCLK,
    input  logic             i_RST,
    k005297_dmaseq_if.master bus
);

    state_e             state_q, state_d;
    logic               wr_q, wr_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               abort_q, abort_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               br_n_q, br_n_d;
    logic               bgack_n_q, bgack_n_d;
    logic               ack_q, ack_d;
    logic               done_q, done_d;

    logic       cen4, cen2;
    logic       abort_any;
    logic       bus_free;
    logic       word_end;
    logic       rot_load, rot_clr, rot_adv, rot_stall;
    logic       rot_last;
    logic [7:0] rot8;

    assign cen4      = ~bus.i_CLK4M_PCEN_n;
    assign cen2      = ~bus.i_CLK2M_PCEN_n;
    assign abort_any = abort_q | bus.i_ABORT;
    assign bus_free  = bus.i_AS_n & bus.i_DTACK_n & bus.i_BGACK_n;
    assign rot_adv   = cen4 & (state_q == ST_CYCLE);
    assign word_end  = rot_adv & rot_last;

`ifdef DMASEQ_DTACK_WAIT_EN
    assign rot_stall = rot8[5] & bus.i_DTACK_n;
`else
    assign rot_stall = 1'b0;
`endif

    k005297_rot8 u_rot8 (
        .i_clk   (i_MCLK),
        .i_rst   (i_RST),
        .i_load  (rot_load),
        .i_adv   (rot_adv),
        .i_clr   (rot_clr),
        .i_stall (rot_stall),
        .o_rot8  (rot8),
        .o_last  (rot_last)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rem_d     = rem_q;
        abort_d   = abort_q;
        addr_d    = addr_q;
        br_n_d    = br_n_q;
        bgack_n_d = bgack_n_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        rot_load  = 1'b0;
        rot_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_ADDR_LD) begin
                    addr_d = bus.i_ADDR;
                end
                if (bus.i_XFER_REQ) begin
                    wr_d    = bus.i_XFER_WR;
                    rem_d   = len_words(bus.i_XFER_LEN);
                    abort_d = 1'b0;
                    br_n_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAITBUS: begin
                if (abort_any) begin
                    abort_d = 1'b0;
                    br_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_REQ) begin
                    if (cen2 && !bus.i_BG_n) begin
                        state_d = ST_WAITBUS;
                    end
                end else if (cen2 && bus_free) begin
                    bgack_n_d = 1'b0;
                    br_n_d    = 1'b1;
                    rot_load  = 1'b1;
                    state_d   = ST_CYCLE;
                end
            end
            ST_CYCLE: begin
                abort_d = abort_any;
                if (word_end) begin
                    ack_d  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - REM_W'(1);
                    // Chain straight into the next word: no phase-0 gap.
                    if (rem_q != REM_W'(1) && !abort_any) begin
                        rot_load = 1'b1;
                    end else begin
                        rot_clr = 1'b1;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (cen2) begin
                    bgack_n_d = 1'b1;
                    done_d    = 1'b1;
                    abort_d   = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            rem_q     <= '0;
            abort_q   <= 1'b0;
            addr_q    <= '0;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rem_q     <= rem_d;
            abort_q   <= abort_d;
            addr_q    <= addr_d;
            br_n_q    <= br_n_d;
            bgack_n_q <= bgack_n_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_BR_n         = br_n_q;
    assign bus.o_BGACK_n      = bgack_n_q;
    assign bus.o_ROT8         = rot8;
    assign bus.o_DMA_ACT      = |rot8;
    assign bus.o_DMA_WR_ACT_n = ~((|rot8) & wr_q);
    assign bus.o_ADDR         = addr_q;
    assign bus.o_WORD_ACK     = ack_q;
    assign bus.o_XFER_DONE    = done_q;

endmodule

// File: tb/tb_k005297_dmaseq.sv
// Testbench for k005297_dmaseq: burst table plus abort, DTACK-wait and reset cases.
// Word addresses are scoreboarded at each phase-0 entry.
module tb_k005297_dmaseq;
    import k005297_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    k005297_dmaseq_if bus ();

    k005297_dmaseq dut (
        .i_MCLK (clk),
        .i_RST  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] addr;
        logic        wr;
        logic [3:0]  len;
        int          abort_word;
        int          exp_acks;
        logic [22:0] exp_end;
    } vec_t;

    vec_t vecs[5];

    int n_pass = 0;
    int n_chk  = 0;

    logic [22:0] exp_q[$];
    logic        exp_wr = 1'b0;

    int   ack_cnt = 0, done_cnt = 0, act_rises = 0;
    int   word_idx = 0, word_en_cnt = 0, last_word_len = 0;
    int   bg_cnt = 0, wait_cnt = 0, gen_cnt = 0;
    int   dly = 0, abort_word = 0;
    bit   abort_fired = 0, bg_grant_en = 1, man_abort = 0;
    logic [7:0] prev_rot = 8'h00;
    logic prev_act = 1'b0, prev_bgack_n = 1'b1;
    int   a0, d0, r0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Clock enables, bus/slave model and monitor, all on the falling edge.
    initial begin
        bus.i_CLK4M_PCEN_n = 1'b1;
        bus.i_CLK2M_PCEN_n = 1'b1;
        bus.i_BG_n         = 1'b1;
        bus.i_DTACK_n      = 1'b1;
        bus.i_ABORT        = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_WORD_ACK) ack_cnt++;
                if (bus.o_XFER_DONE) done_cnt++;
                if (bus.o_DMA_ACT && !prev_act) act_rises++;
                if (!bus.o_BGACK_n && prev_bgack_n)
                    chk("bgack_with_br_high", bus.o_BR_n, 1);
                if (!bus.o_BR_n && bg_grant_en && !bus.i_CLK2M_PCEN_n)
                    bg_cnt++;
                if (prev_rot == 8'h00) word_en_cnt = 0;
                else if (!bus.i_CLK4M_PCEN_n) begin
                    word_en_cnt++;
                    if (prev_rot == 8'h80) begin
                        last_word_len = word_en_cnt;
                        word_en_cnt = 0;
                    end
                end
                if (bus.o_ROT8 != prev_rot) begin
                    chk("rot8_on_4m_enable", bus.i_CLK4M_PCEN_n, 0);
                    if (bus.o_ROT8 == 8'h01) begin
                        if (prev_rot == 8'h00) begin
                            word_idx = 1;
                            abort_fired = 0;
                        end else word_idx++;
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_word: addr %h", bus.o_ADDR);
                        end else begin
                            chk("word_addr", bus.o_ADDR, exp_q.pop_front());
                            chk("wr_act_n", bus.o_DMA_WR_ACT_n, !exp_wr);
                        end
                    end else if (bus.o_ROT8 != 8'h00) begin
                        chk("rot8_step", bus.o_ROT8, {prev_rot[6:0], prev_rot[7]});
                    end
                end
            end
            prev_rot     = bus.o_ROT8;
            prev_act     = bus.o_DMA_ACT;
            prev_bgack_n = bus.o_BGACK_n;

            gen_cnt = (gen_cnt + 1) % 8;
            bus.i_CLK4M_PCEN_n = (gen_cnt % 4) != 0;
            bus.i_CLK2M_PCEN_n = gen_cnt != 0;
            if (bus.o_BR_n) bg_cnt = 0;
            bus.i_BG_n = !(bg_cnt >= 3 && bus.o_BGACK_n);
            if (bus.o_ROT8 == 8'h20) begin
                bus.i_DTACK_n = wait_cnt < dly;
                if (!bus.i_CLK4M_PCEN_n && wait_cnt < dly) wait_cnt++;
            end else begin
                wait_cnt = 0;
                bus.i_DTACK_n = !(|bus.o_ROT8[7:4]);
            end
            bus.i_ABORT = man_abort;
            if (abort_word != 0 && !abort_fired && word_idx == abort_word
                && bus.o_ROT8 == 8'h08) begin
                bus.i_ABORT = 1'b1;
                abort_fired = 1;
            end
        end
    end

    task automatic start_xfer(input logic [22:0] addr, input logic wr,
                              input logic [3:0] len, input int nexp);
        logic [22:0] a;
        a0 = ack_cnt; d0 = done_cnt; r0 = act_rises;
        exp_wr = wr;
        for (int i = 0; i < nexp; i++) begin
            a = addr + 23'(i);
            exp_q.push_back(a);
        end
        @(negedge clk);
        bus.i_ADDR_LD  = 1'b1;
        bus.i_ADDR     = addr;
        bus.i_XFER_REQ = 1'b1;
        bus.i_XFER_WR  = wr;
        bus.i_XFER_LEN = len;
        @(negedge clk);
        bus.i_ADDR_LD  = 1'b0;
        bus.i_XFER_REQ = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (done_cnt == d0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, done_cnt - d0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{23'h000100, 1'b0, 4'd1, 0, 1,  23'h000101};
        vecs[1] = '{23'h000200, 1'b1, 4'd0, 0, 16, 23'h000210};
        vecs[2] = '{23'h7FFFFE, 1'b0, 4'd3, 0, 3,  23'h000001};
        vecs[3] = '{23'h001000, 1'b0, 4'd4, 2, 2,  23'h001002};
        vecs[4] = '{23'h000050, 1'b1, 4'd2, 0, 2,  23'h000052};

        bus.i_XFER_REQ = 1'b0;
        bus.i_XFER_WR  = 1'b0;
        bus.i_XFER_LEN = 4'd0;
        bus.i_ADDR_LD  = 1'b0;
        bus.i_ADDR     = '0;
        bus.i_AS_n     = 1'b1;
        bus.i_BGACK_n  = 1'b1;

        repeat (4) @(negedge clk);
        chk("rst_br_n", bus.o_BR_n, 1);
        chk("rst_bgack_n", bus.o_BGACK_n, 1);
        chk("rst_rot8", bus.o_ROT8, 0);
        chk("rst_dma_act", bus.o_DMA_ACT, 0);
        chk("rst_wr_act_n", bus.o_DMA_WR_ACT_n, 1);
        chk("rst_addr", bus.o_ADDR, 0);
        chk("rst_word_ack", bus.o_WORD_ACK, 0);
        chk("rst_done", bus.o_XFER_DONE, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            abort_word = vecs[i].abort_word;
            start_xfer(vecs[i].addr, vecs[i].wr, vecs[i].len,
                       vecs[i].exp_acks);
            wait_done("vec_done");
            chk("vec_acks", ack_cnt - a0, vecs[i].exp_acks);
            chk("vec_end_addr", bus.o_ADDR, vecs[i].exp_end);
            chk("vec_act_rises", act_rises - r0, 1);
            chk("vec_sb_empty", exp_q.size(), 0);
            chk("vec_bgack_n", bus.o_BGACK_n, 1);
            chk("vec_br_n", bus.o_BR_n, 1);
            abort_word = 0;
        end

        bg_grant_en = 0;
        start_xfer(23'h000300, 1'b0, 4'd2, 0);
        repeat (20) @(negedge clk);
        chk("req_br_low", bus.o_BR_n, 0);
        man_abort = 1;
        @(negedge clk);
        man_abort = 0;
        wait_done("req_abort_done");
        chk("req_abort_br_n", bus.o_BR_n, 1);
        chk("req_abort_no_act", act_rises - r0, 0);
        chk("req_abort_addr", bus.o_ADDR, 23'h000300);
        bg_grant_en = 1;

        dly = 3;
        start_xfer(23'h000400, 1'b0, 4'd1, 1);
        wait_done("dtack_done");
`ifdef DMASEQ_DTACK_WAIT_EN
        chk("dtack_word_len", last_word_len, 11);
`else
        chk("dtack_word_len", last_word_len, 8);
`endif
        chk("dtack_acks", ack_cnt - a0, 1);
        dly = 0;

        start_xfer(23'h000500, 1'b1, 4'd2, 2);
        t = 0;
        while (bus.o_ROT8 != 8'h10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_phase4", bus.o_ROT8, 8'h10);
        #2 rst = 1'b1;
        #1;
        chk("arst_rot8", bus.o_ROT8, 0);
        chk("arst_dma_act", bus.o_DMA_ACT, 0);
        chk("arst_wr_act_n", bus.o_DMA_WR_ACT_n, 1);
        chk("arst_bgack_n", bus.o_BGACK_n, 1);
        chk("arst_br_n", bus.o_BR_n, 1);
        chk("arst_addr", bus.o_ADDR, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_xfer(23'h000600, 1'b1, 4'd2, 2);
        wait_done("post_rst_done");
        chk("post_rst_acks", ack_cnt - a0, 2);
        chk("post_rst_addr", bus.o_ADDR, 23'h000602);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
